// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage, muldiv_unit and the Hi/Lo register.
// The execute stage drives the master side; muldiv_unit sits on the slave side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic               Start;
  logic [2:0]         Op;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] HiLoIn;
  logic               Busy;
  logic               Done;
  logic               WriteEnable;
  logic [2*WIDTH-1:0] Result;
  logic               DivByZero;

  modport master (
    output Start, Op, A, B, HiLoIn,
    input  Busy, Done, WriteEnable, Result, DivByZero
  );

  modport slave (
    input  Start, Op, A, B, HiLoIn,
    output Busy, Done, WriteEnable, Result, DivByZero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider feeding the MIPS Hi/Lo register.
// Define MULDIV_ACCUM_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (Op[2]=1).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          Clock,
  input logic          Reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               isDiv_q;
  logic               sgnA_q;
  logic               sgnB_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] result_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
`ifdef MULDIV_ACCUM_EN
  logic               accum_q;
  logic               sub_q;
  logic [2*WIDTH-1:0] hilo_q;
`endif

  logic               opLegal;
  logic               isDivIn;
  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     shRem;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] result_d;

`ifdef MULDIV_ACCUM_EN
  assign opLegal = 1'b1;
`else
  assign opLegal = ~bus.Op[2];
`endif

  // Signed ops (Op[0]==0) iterate on magnitudes; signs are restored on the final step.
  assign isDivIn = (bus.Op[2:1] == 2'b01);
  assign aNeg    = ~bus.Op[0] & bus.A[WIDTH-1];
  assign bNeg    = ~bus.Op[0] & bus.B[WIDTH-1];
  assign aMag    = aNeg ? -bus.A : bus.A;
  assign bMag    = bNeg ? -bus.B : bus.B;

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    addSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    shRem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial  = {1'b0, shRem} - {2'b00, opnd_q};
    if (isDiv_q) begin
      if (trial[WIDTH+1])
        acc_d = {shRem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {addSum, acc_q[WIDTH-1:1]};
    end

    prod = (sgnA_q ^ sgnB_q) ? -acc_d : acc_d;
    quot = (sgnA_q ^ sgnB_q) ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    rem  = sgnA_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];

    if (isDiv_q) begin
      result_d = {rem, quot};
    end else begin
`ifdef MULDIV_ACCUM_EN
      if (accum_q)
        result_d = sub_q ? (hilo_q - prod) : (hilo_q + prod);
      else
        result_d = prod;
`else
      result_d = prod;
`endif
    end
  end

  // Control FSM; all handshake outputs are registered here.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      isDiv_q  <= 1'b0;
      sgnA_q   <= 1'b0;
      sgnB_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_ACCUM_EN
      accum_q  <= 1'b0;
      sub_q    <= 1'b0;
      hilo_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start && opLegal) begin
            isDiv_q <= isDivIn;
            sgnA_q  <= aNeg;
            sgnB_q  <= bNeg;
            opnd_q  <= isDivIn ? bMag : aMag;
            acc_q   <= {{WIDTH{1'b0}}, (isDivIn ? aMag : bMag)};
            cnt_q   <= '0;
`ifdef MULDIV_ACCUM_EN
            accum_q <= bus.Op[2];
            sub_q   <= bus.Op[1];
            hilo_q  <= bus.HiLoIn;
`endif
            if (isDivIn && (bus.B == '0)) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              dbz_q    <= 1'b1;
              result_q <= {bus.A, {WIDTH{1'b1}}};
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            dbz_q    <= 1'b0;
            result_q <= result_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.WriteEnable = done_q;
  assign bus.Result      = result_q;
  assign bus.DivByZero   = dbz_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-cycle multiply/divide engine for the MIPS datapath. It sits directly upstream of the Hi/Lo register.
- Accepts MULT/MULTU/DIV/DIVU operands from the execute stage. Produces a 64-bit {Hi,Lo} result with a one-cycle write-enable pulse that drives the Hi/Lo register's WriteEnable/WriteData.
- Runs on the rising edge of Clock. The Hi/Lo register captures on the following falling edge, within the same Done cycle.

Parameters:
- WIDTH, 32, operand width. Result is 2*WIDTH. Iteration count equals WIDTH.

Ports:
- Clock  input  1  system clock, rising-edge active
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- Op  input  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
  - 1xx: accumulate ops, see Optional Feature
- A  input  WIDTH  operand A (multiplicand / dividend)
- B  input  WIDTH  operand B (multiplier / divisor)
- HiLoIn  input  2*WIDTH  current Hi/Lo contents; used only by accumulate ops
- Busy  output  1  high while iterating
- Done  output  1  one-cycle pulse; Result valid
- WriteEnable  output  1  equals Done; drives the Hi/Lo write enable
- Result  output  2*WIDTH  {Hi,Lo}:
  - multiply: product
  - divide: {remainder, quotient}
- DivByZero  output  1  valid with Done; high for a divide with B==0

Behaviour:
- Reset, when sampled high at a rising edge:
  - state goes to IDLE; counter cleared
  - Busy=0, Done=0, WriteEnable=0, DivByZero=0, Result=0
  - Reset overrides Start and aborts any operation in progress; no Done is issued for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start=1 with a legal Op at edge E0: latch Op, A, B (and HiLoIn), go to RUN with counter=0.
  - Exception: a divide with B==0 goes directly to DONE.
  - Start in RUN or DONE is ignored and not queued.
- Signed ops (MULT, DIV):
  - operate on magnitudes of A and B
  - product sign = A[msb]^B[msb]
  - quotient sign = A[msb]^B[msb]; remainder sign = A[msb]
  - signs are applied when entering DONE
- Multiply: shift-add, one multiplier bit per cycle.
- Divide: restoring division, one quotient bit per cycle.
- RUN:
  - Busy=1
  - edges E1..E32 each perform one iteration
  - at E32 (counter==WIDTH-1), apply signs, load Result, go to DONE
- DONE:
  - lasts exactly one cycle; Done=1, WriteEnable=1, Busy=0
  - next edge returns to IDLE with Done=0 and WriteEnable=0
- Result holds its value after DONE until the next operation reaches DONE, or until Reset.
- Latency: Done is high in the cycle following E32, i.e. 33 rising edges after E0. A divide by zero completes in the cycle after E0.
- Divide by zero: Result={A, all-ones}, DivByZero=1.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wraps). DivByZero=0.
- All arithmetic is modulo 2^(2*WIDTH); no overflow flags.

Optional Feature:
- Macro: MULDIV_ACCUM_EN
- Defined:
  - Op 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
  - product is computed as for MULT/MULTU
  - entering DONE, Result = HiLoIn_latched ± product, modulo 2^64
  - same latency as multiply
- Undefined:
  - Op[2]=1 is illegal; Start with an illegal Op is ignored and the block stays in IDLE
  - HiLoIn is unused

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Busy high from E1. Done/WriteEnable pulse exactly 33 edges after the Start edge. Result=0xFFFFFFFE00000001.
- MULT A=0xFFFFFFFD (-3) B=7 -> Result=0xFFFFFFFFFFFFFFEB. Then DIVU A=100 B=7 -> Result={0x00000002, 0x0000000E}.
- DIV A=0xFFFFFFF9 (-7) B=2 -> Result={0xFFFFFFFF, 0xFFFFFFFD}. Then DIV A=0x80000000 B=0xFFFFFFFF -> {0x00000000, 0x80000000}, DivByZero=0.
- DIV A=0x00001234 B=0 -> Done in the cycle after the Start edge, Result={0x00001234, 0xFFFFFFFF}, DivByZero=1.
- Start MULTU, re-pulse Start at iteration 5 with different operands, assert Reset at iteration 10:
  - the second Start is ignored
  - after Reset: Busy=0, Result=0, and no Done/WriteEnable for 40 cycles
  - a new Start then completes normally
- With MULDIV_ACCUM_EN: MADD HiLoIn=1 A=2 B=3 -> Result=7; MSUB HiLoIn=0 A=1 B=1 -> Result=0xFFFFFFFFFFFFFFFF.
- Without MULDIV_ACCUM_EN: Op=100 with Start -> Busy stays 0 and no Done.
